sample_collector: RTL and testbench
===================================

Name: sample_collector

Overview:
- Downstream stage of the serial sequencer: consumes its one-word-per-strobe stream (VALUE/VALID) and reassembles NUM_INPUTS words into one parallel vector for the next layer.
- Double-buffered:
  - a shadow buffer collects the next frame while the previous frame waits in the output register for ACK_IN;
  - frames that cannot be delivered are dropped and flagged.

Parameters:
- NUM_INPUTS, 4, words per frame; must be >= 2.
- WIDTH, 8, bits per word.
- CW (localparam), $clog2(NUM_INPUTS), word-counter width.

Ports:
- CLK  in  1  clock, all logic rising-edge.
- RSTN  in  1  reset, asynchronous assert, active-low.
- VALUE_IN  in  WIDTH  serial word from the sequencer.
- VALID_IN  in  1  one-cycle strobe; VALUE_IN is sampled when this is high.
- CLEAR  in  1  synchronous abort: discards the partial frame and clears OVERFLOW.
- ACK_IN  in  1  consumer has taken VALUES_OUT.
- VALUES_OUT  out  NUM_INPUTS*WIDTH  assembled frame; word k sits at [k*WIDTH +: WIDTH].
- VALID_OUT  out  1  level; high while VALUES_OUT holds an unacknowledged frame.
- COUNT  out  CW  words already collected in the current partial frame.
- BUSY  out  1  high when COUNT != 0.
- OVERFLOW  out  1  sticky; a completed frame was dropped.

Behaviour:
- Reset values (async, RSTN low):
  - COUNT = 0, VALID_OUT = 0, OVERFLOW = 0, BUSY = 0.
  - VALUES_OUT and the shadow buffer = 0.
  - Output state = EMPTY.
- Collect path, per cycle with VALID_IN = 1 and CLEAR = 0:
  - shadow[COUNT] <= VALUE_IN.
  - If COUNT < NUM_INPUTS-1: COUNT <= COUNT+1.
  - If COUNT == NUM_INPUTS-1: frame complete, COUNT <= 0. Wrap is explicit, so it is correct for non-power-of-2 NUM_INPUTS.
- Output state machine has two states, EMPTY and PENDING.
- EMPTY, frame completes:
  - VALUES_OUT <= shadow, with the last word taken directly from VALUE_IN.
  - VALID_OUT = 1 from the next cycle (latency 1 cycle after the final VALID_IN edge).
  - Next state PENDING.
- PENDING, ACK_IN = 1 and no completion this cycle: VALID_OUT <= 0, next state EMPTY.
- PENDING, ACK_IN = 1 and completion in the same cycle:
  - New frame loaded, VALID_OUT stays 1, state stays PENDING.
  - Counts as ack + reload; no drop.
- PENDING, ACK_IN = 0 and completion:
  - Frame dropped; VALUES_OUT unchanged.
  - OVERFLOW <= 1; COUNT still wraps to 0.
- EMPTY, ACK_IN = 1: ignored.
- VALUES_OUT is stable whenever VALID_OUT is high and no reload occurs.
- CLEAR = 1:
  - COUNT <= 0 and OVERFLOW <= 0; a VALID_IN in the same cycle is discarded.
  - CLEAR has priority over VALID_IN.
  - The output register and VALID_OUT are unaffected, so a pending frame is still delivered.
- Reset mid-frame: the partial frame is lost; the first word after reset is word 0.
- VALID_IN is honoured every cycle, back-to-back. No upstream backpressure exists; loss is reported only through OVERFLOW.

Decomposition:
- Shared package holds:
  - output-state encodings: EMPTY = 1'b0, PENDING = 1'b1;
  - a clog2-based counter-width helper, shared with the sequencer.
- One natural sub-module, word_shift_buffer: an indexed write register array with async reset. It holds the shadow buffer and its index-to-slot decode.
- Counter and state machine stay in the top.

Test Plan:
- Basic frame, defaults:
  - Stimulus: VALID_IN pulses with 0x11, 0x22, 0x33, 0x44, gaps of 3 cycles.
  - Response: 1 cycle after the 4th, VALUES_OUT = 0x44332211, VALID_OUT = 1, COUNT = 0; ACK_IN drops VALID_OUT the next cycle.
- Back-to-back, no ack:
  - Stimulus: 8 consecutive strobes 0x01..0x08.
  - Response: VALUES_OUT = 0x04030201 stays, OVERFLOW = 1 after the 8th; CLEAR drops OVERFLOW to 0 with VALUES_OUT unchanged.
- Ack coincident with completion:
  - Stimulus: frame A pending; ACK_IN high on the same edge as frame B's last word.
  - Response: VALUES_OUT = B, VALID_OUT stays 1, OVERFLOW = 0.
- CLEAR mid-frame:
  - Stimulus: 2 words, then CLEAR together with a VALID_IN of 0xAA, then 4 words 0x10..0x13.
  - Response: VALUES_OUT = 0x13121110, 0xAA absent; COUNT = 0 and BUSY = 0 right after CLEAR.
- Async reset:
  - Stimulus: RSTN low between clock edges with 3 words collected and a frame pending.
  - Response: all outputs zero immediately, without a clock edge; the next 4 words form a fresh frame.
- Non-power-of-2 configuration:
  - Stimulus: NUM_INPUTS = 3, WIDTH = 4, words 0x1, 0x2, 0x3, 0x4, 0x5, 0x6 with ACK each frame.
  - Response: frames 0x321 then 0x654; COUNT never reaches 3.

Source files
------------

// File: rtl/sample_collector_pkg.sv
// Shared definitions for the collector: output-state encodings and the
// word-counter width helper also used by the serial sequencer.
package sample_collector_pkg;

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } out_state_e;

  // Counter width able to index n words; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_collector_word_shift_buffer.sv
// Shadow buffer: DEPTH word slots, one written per strobe at the slot
// selected by WR_IDX. An index with no matching slot writes nothing.
module word_shift_buffer #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8,
  parameter int IW    = 2
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   WR_EN,
  input  logic [IW-1:0]          WR_IDX,
  input  logic [WIDTH-1:0]       WR_DATA,
  output logic [DEPTH*WIDTH-1:0] WORDS
);

  logic [DEPTH-1:0][WIDTH-1:0] slot;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    // Slot k captures the incoming word when the index decodes to k.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)                          slot[k] <= '0;
      else if (WR_EN && WR_IDX == IW'(k)) slot[k] <= WR_DATA;
    end
  end

  assign WORDS = slot;

endmodule

// File: rtl/sample_collector.sv
// Reassembles NUM_INPUTS serial words into one parallel frame. A shadow
// buffer fills while the previous frame waits for ACK_IN; frames completing
// while the output is still unacknowledged are dropped and flagged.
module sample_collector
  import sample_collector_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  parameter  int WIDTH      = 8,
  localparam int CW         = cnt_width(NUM_INPUTS)
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic [WIDTH-1:0]            VALUE_IN,
  input  logic                        VALID_IN,
  input  logic                        CLEAR,
  input  logic                        ACK_IN,
  output logic [NUM_INPUTS*WIDTH-1:0] VALUES_OUT,
  output logic                        VALID_OUT,
  output logic [CW-1:0]               COUNT,
  output logic                        BUSY,
  output logic                        OVERFLOW
);

  out_state_e                        state;
  logic                              take;
  logic                              last_word;
  logic                              complete;
  logic [(NUM_INPUTS-1)*WIDTH-1:0]   shadow;
  logic [NUM_INPUTS*WIDTH-1:0]       frame;

  // CLEAR wins over a coincident strobe.
  assign take      = VALID_IN && !CLEAR;
  assign last_word = (COUNT == CW'(NUM_INPUTS-1));
  assign complete  = take && last_word;
  assign BUSY      = (COUNT != '0);

  // The final word is never stored: it goes straight from VALUE_IN into the
  // frame, so the shadow only needs NUM_INPUTS-1 slots.
  assign frame = {VALUE_IN, shadow};

  word_shift_buffer #(
    .DEPTH (NUM_INPUTS-1),
    .WIDTH (WIDTH),
    .IW    (CW)
  ) u_shadow (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .WR_EN   (take),
    .WR_IDX  (COUNT),
    .WR_DATA (VALUE_IN),
    .WORDS   (shadow)
  );

  // Word counter with explicit wrap so non-power-of-2 frames work.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)          COUNT <= '0;
    else if (CLEAR)     COUNT <= '0;
    else if (VALID_IN)  COUNT <= last_word ? '0 : COUNT + CW'(1);
  end

  // Output handshake: load on completion, release on ack, drop when stuck.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= EMPTY;
      VALUES_OUT <= '0;
      VALID_OUT  <= 1'b0;
      OVERFLOW   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (complete) begin
            VALUES_OUT <= frame;
            VALID_OUT  <= 1'b1;
            state      <= PENDING;
          end
        end
        PENDING: begin
          if (complete) begin
            // Ack in the same cycle frees the register for the new frame.
            if (ACK_IN) VALUES_OUT <= frame;
            else        OVERFLOW   <= 1'b1;
          end else if (ACK_IN) begin
            VALID_OUT <= 1'b0;
            state     <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if (CLEAR) OVERFLOW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector: default 4x8 instance plus a 3x4
// instance for the non-power-of-2 wrap.
module tb_sample_collector;

  logic        CLK;
  logic        RSTN;

  logic [7:0]  value_in;
  logic        valid_in, clear, ack_in;
  logic [31:0] values_out;
  logic        valid_out, busy, overflow;
  logic [1:0]  count;

  logic [3:0]  value_in3;
  logic        valid_in3, ack_in3;
  logic [11:0] values_out3;
  logic        valid_out3, busy3, overflow3;
  logic [1:0]  count3;

  int tests = 0;
  int fails = 0;

  sample_collector #(.NUM_INPUTS(4), .WIDTH(8)) dut (
    .CLK(CLK), .RSTN(RSTN), .VALUE_IN(value_in), .VALID_IN(valid_in),
    .CLEAR(clear), .ACK_IN(ack_in), .VALUES_OUT(values_out),
    .VALID_OUT(valid_out), .COUNT(count), .BUSY(busy), .OVERFLOW(overflow)
  );

  sample_collector #(.NUM_INPUTS(3), .WIDTH(4)) dut3 (
    .CLK(CLK), .RSTN(RSTN), .VALUE_IN(value_in3), .VALID_IN(valid_in3),
    .CLEAR(1'b0), .ACK_IN(ack_in3), .VALUES_OUT(values_out3),
    .VALID_OUT(valid_out3), .COUNT(count3), .BUSY(busy3), .OVERFLOW(overflow3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One strobe on the 4x8 instance, optional ack on the same edge.
  task automatic send(input logic [7:0] v, input logic ack = 1'b0);
    value_in = v; valid_in = 1'b1; ack_in = ack;
    @(negedge CLK);
    valid_in = 1'b0; ack_in = 1'b0;
  endtask

  task automatic send3(input logic [3:0] v);
    value_in3 = v; valid_in3 = 1'b1;
    @(negedge CLK);
    valid_in3 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  initial begin
    RSTN = 1'b0;
    value_in = '0; valid_in = 1'b0; clear = 1'b0; ack_in = 1'b0;
    value_in3 = '0; valid_in3 = 1'b0; ack_in3 = 1'b0;
    idle(2);
    chk("rst_values", values_out, 32'h0);
    chk("rst_valid",  {31'b0, valid_out}, 32'h0);
    chk("rst_count",  {30'b0, count}, 32'h0);
    chk("rst_busy",   {31'b0, busy}, 32'h0);
    chk("rst_ovf",    {31'b0, overflow}, 32'h0);
    RSTN = 1'b1;
    idle(1);

    // Basic frame with gaps between strobes.
    send(8'h11);
    chk("basic_count1", {30'b0, count}, 32'd1);
    chk("basic_busy1",  {31'b0, busy}, 32'd1);
    idle(3); send(8'h22);
    idle(3); send(8'h33);
    chk("basic_valid_early", {31'b0, valid_out}, 32'd0);
    idle(3); send(8'h44);
    chk("basic_values", values_out, 32'h44332211);
    chk("basic_valid",  {31'b0, valid_out}, 32'd1);
    chk("basic_count0", {30'b0, count}, 32'd0);
    ack_in = 1'b1; @(negedge CLK); ack_in = 1'b0;
    chk("basic_ack", {31'b0, valid_out}, 32'd0);

    // Back-to-back, never acked: second frame is dropped.
    for (int i = 1; i <= 8; i++) begin
      value_in = 8'(i); valid_in = 1'b1;
      @(negedge CLK);
      if (i == 4) chk("b2b_valid4", {31'b0, valid_out}, 32'd1);
      if (i == 7) chk("b2b_ovf7", {31'b0, overflow}, 32'd0);
    end
    valid_in = 1'b0;
    chk("b2b_values", values_out, 32'h04030201);
    chk("b2b_ovf",    {31'b0, overflow}, 32'd1);
    chk("b2b_count",  {30'b0, count}, 32'd0);
    clear = 1'b1; @(negedge CLK); clear = 1'b0;
    chk("clr_ovf",    {31'b0, overflow}, 32'd0);
    chk("clr_values", values_out, 32'h04030201);
    chk("clr_valid",  {31'b0, valid_out}, 32'd1);

    // Frame A still pending; ack lands with frame B's last word.
    send(8'hB1); send(8'hB2); send(8'hB3); send(8'hB4, 1'b1);
    chk("coin_values", values_out, 32'hB4B3B2B1);
    chk("coin_valid",  {31'b0, valid_out}, 32'd1);
    chk("coin_ovf",    {31'b0, overflow}, 32'd0);
    ack_in = 1'b1; @(negedge CLK); ack_in = 1'b0;
    chk("coin_ack", {31'b0, valid_out}, 32'd0);

    // CLEAR mid-frame discards the partial frame and the coincident word.
    send(8'h01); send(8'h02);
    chk("clrmid_count2", {30'b0, count}, 32'd2);
    value_in = 8'hAA; valid_in = 1'b1; clear = 1'b1;
    @(negedge CLK);
    valid_in = 1'b0; clear = 1'b0;
    chk("clrmid_count", {30'b0, count}, 32'd0);
    chk("clrmid_busy",  {31'b0, busy}, 32'd0);
    send(8'h10); send(8'h11); send(8'h12); send(8'h13);
    chk("clrmid_values", values_out, 32'h13121110);
    chk("clrmid_valid",  {31'b0, valid_out}, 32'd1);

    // Async reset between edges with a pending frame and 3 words collected.
    send(8'h55); send(8'h66); send(8'h77);
    chk("ar_count3", {30'b0, count}, 32'd3);
    #2 RSTN = 1'b0;
    #1;
    chk("ar_values", values_out, 32'h0);
    chk("ar_valid",  {31'b0, valid_out}, 32'd0);
    chk("ar_count",  {30'b0, count}, 32'd0);
    chk("ar_busy",   {31'b0, busy}, 32'd0);
    chk("ar_ovf",    {31'b0, overflow}, 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    idle(1);
    send(8'hA0);
    chk("ar_word0_valid", {31'b0, valid_out}, 32'd0);
    send(8'hA1); send(8'hA2); send(8'hA3);
    chk("ar_fresh", values_out, 32'hA3A2A1A0);
    chk("ar_fresh_valid", {31'b0, valid_out}, 32'd1);

    // Non-power-of-2 instance: 3 words of 4 bits.
    send3(4'h1); chk("np2_count1", {30'b0, count3}, 32'd1);
    send3(4'h2); chk("np2_count2", {30'b0, count3}, 32'd2);
    send3(4'h3); chk("np2_count3", {30'b0, count3}, 32'd0);
    chk("np2_frame1", {20'b0, values_out3}, 32'h321);
    chk("np2_valid1", {31'b0, valid_out3}, 32'd1);
    ack_in3 = 1'b1; @(negedge CLK); ack_in3 = 1'b0;
    chk("np2_ack1", {31'b0, valid_out3}, 32'd0);
    send3(4'h4); chk("np2_count4", {30'b0, count3}, 32'd1);
    send3(4'h5); chk("np2_count5", {30'b0, count3}, 32'd2);
    send3(4'h6); chk("np2_count6", {30'b0, count3}, 32'd0);
    chk("np2_frame2", {20'b0, values_out3}, 32'h654);
    chk("np2_ovf", {31'b0, overflow3}, 32'd0);
    ack_in3 = 1'b1; @(negedge CLK); ack_in3 = 1'b0;
    chk("np2_ack2", {31'b0, valid_out3}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
